fetch_stage: RTL

Instruction-fetch stage directly upstream of the hazard detection unit. It owns the PC, talks to instruction memory through a req/gnt/rvalid handshake (one outstanding request), buffers a returned word while decode is stalled, and drives the IF/ID pipeline register whose instruction feeds instr_id. It obeys PC/IF enables, applies control-hazard flushes and redirects, and inserts bubbles when memory is slow.

---
 rtl/rv_pipe_pkg.sv | 22 ++
 rtl/if_id_reg.sv | 36 +++
 rtl/fetch_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared types and constants for the RV pipeline front end.
//   fetch_state_e : fetch FSM states
//   if_id_t       : IF/ID pipeline register contents
//   NOP_INSTR     : bubble encoding (addi x0,x0,0)
package rv_pipe_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ,   // request on the bus, waiting for gnt
      S_WAIT,  // granted, waiting for rvalid
      S_DROP,  // redirected while a request was in flight; swallow its response
      S_HOLD   // response parked in the buffer while decode is stalled
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
   } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   i_clk, i_reset        : clock, synchronous active-high reset (loads a bubble, pc 0)
//   i_enable              : load i_instr/i_pc/i_valid; when low all fields hold
//   i_flush               : load a bubble regardless of i_enable
//   i_instr, i_pc, i_valid: next contents
//   o_instr, o_pc, o_valid: current contents
module if_id_reg
   import rv_pipe_pkg::*;
#(
   parameter logic [31:0] NOP = rv_pipe_pkg::NOP_INSTR
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_enable,
   input  logic        i_flush,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pc,
   input  logic        i_valid,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc,
   output logic        o_valid
);

   if_id_t if_id_q;

   always_ff @(posedge i_clk) begin
      if (i_reset)       if_id_q <= '{instr: NOP,     pc: 32'h0, valid: 1'b0};
      else if (i_flush)  if_id_q <= '{instr: NOP,     pc: i_pc,  valid: 1'b0};
      else if (i_enable) if_id_q <= '{instr: i_instr, pc: i_pc,  valid: i_valid};
   end

   assign o_instr = if_id_q.instr;
   assign o_pc    = if_id_q.pc;
   assign o_valid = if_id_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding
// req/gnt/rvalid handshake to instruction memory, parks a returned word
// while decode is stalled, and feeds the IF/ID register.
//   i_clk, i_reset              : clock, synchronous active-high reset
//   i_enable_pc, i_enable_if    : PC advance / IF/ID load enables (stall when low)
//   i_flush, i_redirect_pc      : control-hazard redirect; bubbles IF/ID
//   o_imem_req, o_imem_addr     : fetch request and word-aligned byte address
//   i_imem_gnt                  : request accepted
//   i_imem_rvalid, i_imem_rdata : response
//   o_instr_id, o_pc_id, o_valid_id : IF/ID contents
//   o_misaligned                : last redirect target had bits[1:0] != 0
module fetch_stage
   import rv_pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_enable_pc,
   input  logic        i_enable_if,
   input  logic        i_flush,
   input  logic [31:0] i_redirect_pc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_instr_id,
   output logic [31:0] o_pc_id,
   output logic        o_valid_id,
   output logic        o_misaligned
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  req_pc_q, req_pc_d;
   logic [31:0]  buf_q, buf_d;
   logic         mis_q, mis_d;
   logic         req_c;
   logic         outstanding;
   logic [31:0]  ld_instr, ld_pc;
   logic         ld_valid;

   // A request is in flight at this edge if it was granted earlier and its
   // response is not arriving now, or if it is being granted right now.
   assign outstanding = ((state_q == S_WAIT || state_q == S_DROP) && !i_imem_rvalid) ||
                        (state_q == S_REQ && i_imem_gnt);

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      buf_d    = buf_q;
      mis_d    = mis_q;
      req_c    = 1'b0;
      // Anything not delivering a real word this cycle loads a bubble.
      ld_instr = NOP_INSTR;
      ld_pc    = pc_q;
      ld_valid = 1'b0;

      unique case (state_q)
         S_REQ: begin
            req_c = 1'b1;
            if (i_imem_gnt) begin
               state_d  = S_WAIT;
               req_pc_d = pc_q;
            end
         end
         S_WAIT: begin
            if (i_imem_rvalid) begin
               if (i_enable_if && i_enable_pc) begin
                  ld_instr = i_imem_rdata;
                  ld_pc    = req_pc_q;
                  ld_valid = 1'b1;
                  pc_d     = req_pc_q + 32'd4;
                  state_d  = S_REQ;
               end else begin
                  // Either stage is stalled: park the word until release.
                  buf_d   = i_imem_rdata;
                  state_d = S_HOLD;
               end
            end
         end
         S_DROP: begin
            if (i_imem_rvalid) state_d = S_REQ;
         end
         S_HOLD: begin
            if (i_enable_if) begin
               ld_instr = buf_q;
               ld_pc    = req_pc_q;
               ld_valid = 1'b1;
               if (i_enable_pc) pc_d = req_pc_q + 32'd4;
               buf_d    = 32'h0;
               state_d  = S_REQ;
            end
         end
      endcase

      // Redirect wins over stalls and the FSM.
      if (i_flush) begin
         pc_d    = {i_redirect_pc[31:2], 2'b00};
         mis_d   = |i_redirect_pc[1:0];
         buf_d   = 32'h0;
         state_d = outstanding ? S_DROP : S_REQ;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= S_REQ;
         pc_q     <= RESET_PC;
         req_pc_q <= RESET_PC;
         buf_q    <= 32'h0;
         mis_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         buf_q    <= buf_d;
         mis_q    <= mis_d;
      end
   end

   assign o_imem_req   = req_c && !i_reset;
   assign o_imem_addr  = pc_q;
   assign o_misaligned = mis_q;

   if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_enable (i_enable_if),
      .i_flush  (i_flush),
      .i_instr  (ld_instr),
      .i_pc     (ld_pc),
      .i_valid  (ld_valid),
      .o_instr  (o_instr_id),
      .o_pc     (o_pc_id),
      .o_valid  (o_valid_id)
   );

endmodule
